// File: rtl/mem_arbiter_pkg.sv
// Types shared by the memory arbiter: FSM state enum and pending-response record.
// No logic, no latency.
// No flow control; pure declarations.
`include "defines.vh"

package mem_arbiter_pkg;

    localparam int WORD_W = `WORD_SIZE;

    typedef enum logic {
        IDLE = `ST_IDLE,
        RESP = `ST_RESP
    } state_t;

    // What the RESP cycle needs to remember about the access granted in IDLE.
    typedef struct packed {
        logic win;      // requester index that was granted
        logic is_load;  // 1 = load, rdata carries mem_rdata in RESP
    } pend_t;

endpackage

// File: rtl/defines.vh
// Shared build constants for the memory arbiter: word size and FSM state codes.
// Included by the package and the top so every file agrees on the encodings.
// Guarded so that repeated inclusion within one compilation unit is harmless.
`ifndef MEM_ARBITER_DEFINES_VH
`define MEM_ARBITER_DEFINES_VH

`define WORD_SIZE 8
`define ST_IDLE   1'b0
`define ST_RESP   1'b1

`endif

// File: rtl/mem_arbiter_pick.sv
// Two-way winner selection: a lone requester wins, ties go to the one not granted last.
// Purely combinational, 0 cycles.
// No backpressure; the caller decides whether the pick is acted on.
module arb_pick (
    input  logic req0,
    input  logic req1,
    input  logic last_win,
    output logic win,
    output logic any_req
);

    // Tie-break favours the requester that did not win most recently.
    always_comb begin
        any_req = req0 | req1;
        win     = 1'b0;
        if (req0 && req1) begin
            win = ~last_win;
        end else if (req1) begin
            win = 1'b1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-requester single-port memory arbiter (CPU = 0, loader = 1); ARB_ROUND_ROBIN_EN selects fair ties.
// Latency: gnt combinational in IDLE, rvalid one cycle after gnt; one access per two cycles.
// Requests seen in RESP are not accepted; requesters hold req/we/addr/wdata until gnt.
`include "defines.vh"

module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int WIDTH = `WORD_SIZE
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             req0,
    input  logic             req1,
    input  logic             we0,
    input  logic             we1,
    input  logic [WIDTH-1:0] addr0,
    input  logic [WIDTH-1:0] addr1,
    input  logic [WIDTH-1:0] wdata0,
    input  logic [WIDTH-1:0] wdata1,
    output logic             gnt0,
    output logic             gnt1,
    output logic             rvalid0,
    output logic             rvalid1,
    output logic [WIDTH-1:0] rdata,
    output logic             mem_load,
    output logic             mem_store,
    output logic [WIDTH-1:0] mem_addr,
    output logic [WIDTH-1:0] mem_wdata,
    input  logic [WIDTH-1:0] mem_rdata
);

    state_t state_q, state_d;
    pend_t  pend_q, pend_d;
    logic   last_win;
    logic   pick_win;
    logic   pick_any;
    logic   win_we;

    arb_pick u_pick (
        .req0     (req0),
        .req1     (req1),
        .last_win (last_win),
        .win      (pick_win),
        .any_req  (pick_any)
    );

`ifdef ARB_ROUND_ROBIN_EN
    logic rr_last_q;

    // Remember the last granted requester; reset value makes requester 0 win the first tie.
    always_ff @(posedge clk) begin
        if (areset) begin
            rr_last_q <= 1'b1;
        end else if (gnt0 || gnt1) begin
            rr_last_q <= gnt1;
        end
    end

    assign last_win = rr_last_q;
`else
    // Fixed priority: pretending requester 1 always won last makes requester 0 win every tie.
    assign last_win = 1'b1;
`endif

    assign win_we = pick_win ? we1 : we0;

    // Next state and all outputs; reset overrides everything so nothing leaks while it is high.
    always_comb begin
        state_d   = state_q;
        pend_d    = pend_q;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        rvalid0   = 1'b0;
        rvalid1   = 1'b0;
        rdata     = '0;
        mem_load  = 1'b0;
        mem_store = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;

        case (state_q)
            IDLE: begin
                if (pick_any) begin
                    state_d        = RESP;
                    pend_d.win     = pick_win;
                    pend_d.is_load = ~win_we;
                    gnt0           = ~pick_win;
                    gnt1           = pick_win;
                    mem_load       = ~win_we;
                    mem_store      = win_we;
                    mem_addr       = pick_win ? addr1 : addr0;
                    mem_wdata      = pick_win ? wdata1 : wdata0;
                end
            end
            RESP: begin
                state_d = IDLE;
                rvalid0 = ~pend_q.win;
                rvalid1 = pend_q.win;
                rdata   = pend_q.is_load ? mem_rdata : '0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (areset) begin
            state_d   = IDLE;
            pend_d    = '0;
            gnt0      = 1'b0;
            gnt1      = 1'b0;
            rvalid0   = 1'b0;
            rvalid1   = 1'b0;
            rdata     = '0;
            mem_load  = 1'b0;
            mem_store = 1'b0;
            mem_addr  = '0;
            mem_wdata = '0;
        end
    end

    // State and pending-access record; the record routes rvalid in the RESP cycle.
    always_ff @(posedge clk) begin
        if (areset) begin
            state_q <= IDLE;
            pend_q  <= '0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a transaction-level model is checked every cycle,
// and hand-computed literal expectations pin the scenarios of interest.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int W  = WORD_W;
    localparam int OW = 6 + 3 * W;
    localparam int MS = 1 << W;

    logic         clk = 1'b0;
    logic         areset;
    logic         req0, req1, we0, we1;
    logic [W-1:0] addr0, addr1, wdata0, wdata1;
    logic         gnt0, gnt1, rvalid0, rvalid1;
    logic [W-1:0] rdata;
    logic         mem_load, mem_store;
    logic [W-1:0] mem_addr, mem_wdata;
    logic [W-1:0] mem_rdata;

    int n_vec = 0;
    int n_err = 0;
    logic run = 1'b0;

    logic [W-1:0] env_mem [0:MS-1];
    logic [W-1:0] mdl_mem [0:MS-1];

    logic [OW-1:0] outs;
    assign outs = {gnt0, gnt1, rvalid0, rvalid1, mem_load, mem_store, rdata, mem_addr, mem_wdata};

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk       (clk),
        .areset    (areset),
        .req0      (req0),
        .req1      (req1),
        .we0       (we0),
        .we1       (we1),
        .addr0     (addr0),
        .addr1     (addr1),
        .wdata0    (wdata0),
        .wdata1    (wdata1),
        .gnt0      (gnt0),
        .gnt1      (gnt1),
        .rvalid0   (rvalid0),
        .rvalid1   (rvalid1),
        .rdata     (rdata),
        .mem_load  (mem_load),
        .mem_store (mem_store),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // Environment memory: read data appears the cycle after the load strobe.
    always @(posedge clk) begin
        if (mem_load) mem_rdata <= env_mem[mem_addr];
        if (mem_store) env_mem[mem_addr] <= mem_wdata;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Transaction-level model: busy flag, pending result, last winner, shadow memory.
    logic         m_busy = 1'b0;
    logic         m_pw   = 1'b0;
    logic         m_last = 1'b1;
    logic [W-1:0] m_pdata = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (run) begin
                logic         e_g0, e_g1, e_v0, e_v1, e_ld, e_st, w, wwe;
                logic [W-1:0] e_rd, e_ad, e_wd;
                e_g0 = 0; e_g1 = 0; e_v0 = 0; e_v1 = 0; e_ld = 0; e_st = 0;
                e_rd = '0; e_ad = '0; e_wd = '0;
                if (areset) begin
                    m_busy = 0;
                    m_last = 1;
                end else if (m_busy) begin
                    if (m_pw) e_v1 = 1; else e_v0 = 1;
                    e_rd   = m_pdata;
                    m_busy = 0;
                end else if (req0 || req1) begin
                    if (req0 && req1) begin
`ifdef ARB_ROUND_ROBIN_EN
                        w = !m_last;
`else
                        w = 0;
`endif
                    end else begin
                        w = req1;
                    end
                    wwe  = w ? we1 : we0;
                    e_ad = w ? addr1 : addr0;
                    e_wd = w ? wdata1 : wdata0;
                    if (w) e_g1 = 1; else e_g0 = 1;
                    if (wwe) e_st = 1; else e_ld = 1;
                    m_pdata = wwe ? '0 : mdl_mem[e_ad];
                    if (wwe) mdl_mem[e_ad] = e_wd;
                    m_pw   = w;
                    m_last = w;
                    m_busy = 1;
                end
                chk("model", 64'(outs),
                    64'({e_g0, e_g1, e_v0, e_v1, e_ld, e_st, e_rd, e_ad, e_wd}));
                chk("ld_st_exclusive", 64'(mem_load & mem_store), 64'(0));
            end
        end
    end

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic smp();
        @(negedge clk);
    endtask

    logic [1:0] gr [8];

    initial begin
        for (int i = 0; i < MS; i++) begin
            env_mem[i] = W'(i) ^ W'(8'hA5);
            mdl_mem[i] = W'(i) ^ W'(8'hA5);
        end
        env_mem[8'h10] = 8'h2A;
        mdl_mem[8'h10] = 8'h2A;
        mem_rdata = '0;
        areset = 1; req0 = 0; req1 = 0; we0 = 0; we1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;
        run = 1;

        // Reset state
        smp(); chk("rst_outs", 64'(outs), 64'(0));
        nxt(); smp();
        nxt(); areset = 0; smp(); chk("idle_outs", 64'(outs), 64'(0));

        // Single load
        nxt(); req0 = 1; we0 = 0; addr0 = 8'h10;
        smp(); chk("ld_gnt0", 64'(gnt0), 1); chk("ld_strobe", 64'(mem_load), 1);
        chk("ld_addr", 64'(mem_addr), 64'h10);
        nxt(); req0 = 0;
        smp(); chk("ld_rvalid0", 64'(rvalid0), 1); chk("ld_rdata", 64'(rdata), 64'h2A);

        // Single store then read-back
        nxt(); req1 = 1; we1 = 1; addr1 = 8'h05; wdata1 = 8'h07;
        smp(); chk("st_gnt1", 64'(gnt1), 1); chk("st_strobe", 64'({mem_store, mem_load}), 64'b10);
        chk("st_wdata", 64'(mem_wdata), 64'h07);
        nxt(); req1 = 0; we1 = 0;
        smp(); chk("st_rvalid1", 64'(rvalid1), 1); chk("st_rdata", 64'(rdata), 0);
        nxt(); req0 = 1; we0 = 0; addr0 = 8'h05;
        smp(); chk("rb_gnt0", 64'(gnt0), 1);
        nxt(); req0 = 0;
        smp(); chk("rb_rdata", 64'(rdata), 64'h07);

        // Contention from a fresh pointer
        nxt(); areset = 1; smp();
        nxt(); areset = 0; req0 = 1; req1 = 1; addr0 = 8'h20; addr1 = 8'h21;
        for (int i = 0; i < 8; i++) begin
            if (i > 0) nxt();
            smp();
            gr[i] = {gnt1, gnt0};
        end
        for (int i = 0; i < 8; i++) begin
            logic [1:0] eg;
            if (i % 2 == 1) eg = 2'b00;
`ifdef ARB_ROUND_ROBIN_EN
            else eg = (i % 4 == 0) ? 2'b01 : 2'b10;
`else
            else eg = 2'b01;
`endif
            chk($sformatf("contend_gnt_%0d", i), 64'(gr[i]), 64'(eg));
        end
        nxt(); req0 = 0; req1 = 0; smp();

        // Reset in the response cycle drops the response
        nxt(); req0 = 1; addr0 = 8'h10;
        smp(); chk("rm_gnt0", 64'(gnt0), 1);
        nxt(); req0 = 0; areset = 1;
        smp(); chk("rm_no_rvalid", 64'({rvalid0, rvalid1}), 0); chk("rm_outs", 64'(outs), 0);
        nxt(); areset = 0;
        smp(); chk("rm_after_outs", 64'(outs), 0);

        // Request arriving in RESP waits for the next IDLE
        nxt(); req0 = 1; addr0 = 8'h10;
        smp(); chk("rr_gnt0", 64'(gnt0), 1);
        nxt(); req0 = 0; req1 = 1; we1 = 0; addr1 = 8'h05;
        smp(); chk("rr_no_gnt1", 64'(gnt1), 0); chk("rr_rvalid0", 64'(rvalid0), 1);
        nxt();
        smp(); chk("rr_gnt1", 64'(gnt1), 1); chk("rr_addr", 64'(mem_addr), 64'h05);
        nxt(); req1 = 0;
        smp(); chk("rr_rvalid1", 64'(rvalid1), 1); chk("rr_rdata", 64'(rdata), 64'h07);

        // Request pulsed only during RESP is withdrawn
        nxt(); req0 = 1; addr0 = 8'h10;
        smp(); chk("wd_gnt0", 64'(gnt0), 1);
        nxt(); req0 = 0; req1 = 1;
        smp(); chk("wd_no_gnt1_resp", 64'(gnt1), 0);
        nxt(); req1 = 0;
        smp(); chk("wd_quiet", 64'({gnt1, mem_load, mem_store}), 0);

        // No grant while reset is high; held request granted afterwards
        nxt(); areset = 1; req0 = 1; addr0 = 8'h10;
        smp(); chk("ar_no_gnt", 64'({gnt0, mem_load}), 0);
        nxt(); areset = 0;
        smp(); chk("ar_gnt0", 64'(gnt0), 1);
        nxt(); req0 = 0;
        smp(); chk("ar_rdata", 64'(rdata), 64'h2A);

        nxt(); smp();
        run = 0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
